// File: rtl/turn_remote_rx_fsm.sv
// turn_remote_rx_fsm
// Receive side of the inter-board "space" link. It synchronises and
// glitch-filters the remote space level, then replays the remote player's
// press / hold / release / throw sequence as local index and throw controls.
// A line held high for too long in HOLD is reported as a stuck-line fault.

module turn_remote_rx_fsm #(
  parameter int unsigned FILTER_CYCLES = 16,
  parameter int unsigned THROW_CYCLES  = 65000000,
  parameter int unsigned HOLD_TIMEOUT  = 650000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       space_pin_rx,
  input  logic       whose_turn,
  output logic [1:0] index,
  output logic       throw_enable,
  output logic       throw_done,
  output logic       rx_fault
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HOLD  = 3'd1;
  localparam logic [2:0] ST_THROW = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  localparam logic [31:0] FILT_LAST  = 32'(FILTER_CYCLES - 1);
  localparam logic [31:0] THROW_LAST = 32'(THROW_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST  = 32'(HOLD_TIMEOUT - 1);

  // Synchroniser, filter and edge-detect state
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        filt_q, filt_d;
  logic        filt_dly_q, filt_dly_d;
  logic [31:0] filt_cnt_q, filt_cnt_d;
  logic        rise_s, fall_s;

  // Sequence FSM state
  logic [2:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;

  // Registered outputs
  logic [1:0]  index_q, index_d;
  logic        throw_enable_q, throw_enable_d;
  logic        throw_done_q, throw_done_d;
  logic        rx_fault_q, rx_fault_d;

  // Two-flop synchroniser on the asynchronous pin and the delayed filtered copy
  always_comb begin
    sync1_d    = space_pin_rx;
    sync2_d    = sync1_q;
    filt_dly_d = filt_q;
  end

  // Glitch filter: the filtered level moves only after a run of differing samples
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = 32'd0;
    if (sync2_q != filt_q) begin
      if (filt_cnt_q < FILT_LAST) begin
        filt_cnt_d = filt_cnt_q + 32'd1;
      end else begin
        filt_d     = ~filt_q;
        filt_cnt_d = 32'd0;
      end
    end else begin
      filt_cnt_d = 32'd0;
    end
  end

  // Edge detection on the filtered level
  always_comb begin
    rise_s = filt_q & ~filt_dly_q;
    fall_s = ~filt_q & filt_dly_q;
  end

  // Next-state logic; a local turn overrides everything and parks the FSM in IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 32'd0;
        if (rise_s) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (fall_s) begin
          state_d = ST_THROW;
          cnt_d   = 32'd0;
        end else if (cnt_q < HOLD_LAST) begin
          cnt_d = cnt_q + 32'd1;
        end else begin
          state_d = ST_FAULT;
          cnt_d   = 32'd0;
        end
      end
      ST_THROW: begin
        // A new press during the throw window is deliberately not latched.
        if (cnt_q < THROW_LAST) begin
          cnt_d = cnt_q + 32'd1;
        end else begin
          state_d = ST_DONE;
          cnt_d   = 32'd0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = 32'd0;
      end
      ST_FAULT: begin
        cnt_d = 32'd0;
        if (!filt_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 32'd0;
      end
    endcase
    if (!whose_turn) begin
      state_d = ST_IDLE;
      cnt_d   = 32'd0;
    end else begin
      state_d = state_d;
    end
  end

  // Output decode from the next state so outputs appear together with the state
  always_comb begin
    index_d        = 2'd0;
    throw_enable_d = 1'b0;
    throw_done_d   = 1'b0;
    rx_fault_d     = 1'b0;
    case (state_d)
      ST_IDLE: begin
        index_d = 2'd0;
      end
      ST_HOLD: begin
        index_d = 2'd1;
      end
      ST_THROW: begin
        index_d        = 2'd2;
        throw_enable_d = 1'b1;
      end
      ST_DONE: begin
        index_d      = 2'd2;
        throw_done_d = 1'b1;
      end
      ST_FAULT: begin
        index_d    = 2'd0;
        rx_fault_d = 1'b1;
      end
      default: begin
        index_d = 2'd0;
      end
    endcase
  end

  // All state and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      filt_q         <= 1'b0;
      filt_dly_q     <= 1'b0;
      filt_cnt_q     <= 32'd0;
      state_q        <= ST_IDLE;
      cnt_q          <= 32'd0;
      index_q        <= 2'd0;
      throw_enable_q <= 1'b0;
      throw_done_q   <= 1'b0;
      rx_fault_q     <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      filt_q         <= filt_d;
      filt_dly_q     <= filt_dly_d;
      filt_cnt_q     <= filt_cnt_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      index_q        <= index_d;
      throw_enable_q <= throw_enable_d;
      throw_done_q   <= throw_done_d;
      rx_fault_q     <= rx_fault_d;
    end
  end

  assign index        = index_q;
  assign throw_enable = throw_enable_q;
  assign throw_done   = throw_done_q;
  assign rx_fault     = rx_fault_q;

endmodule

// File: tb/tb_turn_remote_rx_fsm.sv
// Scoreboard bench for turn_remote_rx_fsm. Stimulus pushes the expected
// output vector and the cycle it must appear in; the monitor pops one entry
// every time the DUT output vector changes and compares value and cycle.

module tb_turn_remote_rx_fsm;

  localparam int unsigned FC = 4;
  localparam int unsigned TC = 10;
  localparam int unsigned HT = 50;

  // Output vector: {index[1:0], throw_enable, throw_done, rx_fault}
  localparam logic [4:0] O_IDLE  = 5'b00000;
  localparam logic [4:0] O_HOLD  = 5'b01000;
  localparam logic [4:0] O_THROW = 5'b10100;
  localparam logic [4:0] O_DONE  = 5'b10010;
  localparam logic [4:0] O_FAULT = 5'b00001;

  // Pin edge to filtered edge is 2 + FC cycles, one more for the registered output
  localparam int unsigned LAT = 2 + FC + 1;

  typedef struct packed {
    int unsigned cyc;
    logic [4:0]  val;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       space_pin_rx;
  logic       whose_turn;
  logic [1:0] index;
  logic       throw_enable;
  logic       throw_done;
  logic       rx_fault;

  exp_t        exp_q[$];
  int unsigned cyc;
  int          n_cmp;
  int          n_fail;
  bit          done;

  turn_remote_rx_fsm #(
    .FILTER_CYCLES(FC),
    .THROW_CYCLES (TC),
    .HOLD_TIMEOUT (HT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .space_pin_rx(space_pin_rx),
    .whose_turn  (whose_turn),
    .index       (index),
    .throw_enable(throw_enable),
    .throw_done  (throw_done),
    .rx_fault    (rx_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to timestamp expected and observed events
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_at(input int unsigned off, input logic [4:0] v);
    exp_t e;
    e.cyc = cyc + off;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic press();
    space_pin_rx = 1'b1;
    expect_at(LAT, O_HOLD);
  endtask

  // Release: THROW for TC cycles, one DONE cycle, then IDLE
  task automatic release_throw();
    space_pin_rx = 1'b0;
    expect_at(LAT, O_THROW);
    expect_at(LAT + TC, O_DONE);
    expect_at(LAT + TC + 1, O_IDLE);
  endtask

  // Release followed by an abort at throw cycle 5
  task automatic release_and_abort(input bit use_rst);
    space_pin_rx = 1'b0;
    expect_at(LAT, O_THROW);
    wait_cyc(LAT + 5);
    if (use_rst) rst = 1'b0;
    else         whose_turn = 1'b0;
    expect_at(1, O_IDLE);
    wait_cyc(5);
    rst        = 1'b1;
    whose_turn = 1'b1;
    wait_cyc(10);
  endtask

  // Monitor: reset check, then one scoreboard pop per output change
  initial begin
    logic [4:0] cur;
    logic [4:0] prev;
    exp_t       e;
    n_cmp  = 0;
    n_fail = 0;
    wait_cyc(3);
    cur = {index, throw_enable, throw_done, rx_fault};
    n_cmp = n_cmp + 1;
    if (cur !== O_IDLE) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_state got=%b want=%b", cur, O_IDLE);
    end
    prev = O_IDLE;
    while (!done) begin
      @(negedge clk);
      cur = {index, throw_enable, throw_done, rx_fault};
      if (cur !== prev) begin
        n_cmp = n_cmp + 1;
        if (exp_q.size() == 0) begin
          n_fail = n_fail + 1;
          $display("FAIL unexpected_change cyc=%0d got=%b want=no_change", cyc, cur);
        end else begin
          e = exp_q.pop_front();
          if (e.val !== cur || e.cyc != cyc) begin
            n_fail = n_fail + 1;
            $display("FAIL output_event got=%b@%0d want=%b@%0d", cur, cyc, e.val, e.cyc);
          end
        end
        prev = cur;
      end
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp  = n_cmp + 1;
      n_fail = n_fail + 1;
      $display("FAIL missing_event got=none want=%b@%0d", e.val, e.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Directed stimulus
  initial begin
    done         = 1'b0;
    rst          = 1'b0;
    whose_turn   = 1'b0;
    space_pin_rx = 1'b0;
    wait_cyc(4);
    rst        = 1'b1;
    whose_turn = 1'b1;
    wait_cyc(10);

    // 1. Normal throw
    press();
    wait_cyc(20);
    release_throw();
    wait_cyc(25);

    // 2. Glitch rejection: 3-cycle pulses never pass a 4-sample filter
    for (int i = 0; i < 5; i++) begin
      space_pin_rx = 1'b1;
      wait_cyc(3);
      space_pin_rx = 1'b0;
      wait_cyc(3);
    end
    wait_cyc(10);

    // 3. Turn gating, then a line already high when the turn arrives
    whose_turn = 1'b0;
    wait_cyc(2);
    space_pin_rx = 1'b1;
    wait_cyc(20);
    space_pin_rx = 1'b0;
    wait_cyc(20);
    space_pin_rx = 1'b1;
    wait_cyc(10);
    whose_turn = 1'b1;
    wait_cyc(20);
    space_pin_rx = 1'b0;
    wait_cyc(10);
    press();
    wait_cyc(15);
    release_throw();
    wait_cyc(25);

    // 4. Stuck line: 50 cycles in HOLD, then FAULT until the line drops
    press();
    expect_at(LAT + HT, O_FAULT);
    wait_cyc(100);
    space_pin_rx = 1'b0;
    expect_at(LAT, O_IDLE);
    wait_cyc(20);

    // 5. Abort mid-throw by whose_turn, then by reset
    press();
    wait_cyc(20);
    release_and_abort(1'b0);
    press();
    wait_cyc(20);
    release_and_abort(1'b1);

    // 6. Press during THROW is ignored; a fresh rise is needed afterwards
    press();
    wait_cyc(20);
    release_throw();
    wait_cyc(LAT + 3);
    space_pin_rx = 1'b1;
    wait_cyc(20);
    space_pin_rx = 1'b0;
    wait_cyc(10);
    press();
    wait_cyc(15);
    release_throw();
    wait_cyc(25);

    done = 1'b1;
  end

endmodule
